// File: rtl/sext_pack_pkg.sv
// Shared types and constants for the sign-extension packer.
package sext_pack_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;

    localparam logic OP_IMM5 = 1'b0;
    localparam logic OP_IMM8 = 1'b1;

endpackage

// File: rtl/sext_fit.sv
// Combinational test: does the 16-bit word equal the sign extension of its 5- or 8-bit field?
module sext_fit
    import sext_pack_pkg::*;
(
    input  logic [15:0] word,
    input  logic        op,
    output logic        fits
);

    always_comb begin
        fits = 1'b0;
        if (op == OP_IMM8) begin
            fits = (word[15:7] == {9{word[7]}});
        end else begin
            fits = (word[15:4] == {12{word[4]}});
        end
    end

endmodule

// File: rtl/sext_pack.sv
// Packs 16-bit words into one byte (sign-extendable) or two bytes (low, then high).
// Optional macro SEXT_PACK_STATS_EN adds the short_cnt compressed-word counter.
module sext_pack
    import sext_pack_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_word,
    input  logic        in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_short,
    output logic        out_last
`ifdef SEXT_PACK_STATS_EN
    ,
    output logic [15:0] short_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_* stay frozen while out_valid=1 and out_ready=0.

    state_e      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic        out_valid_q, out_valid_d;
    logic        out_short_q, out_short_d;
    logic        out_last_q, out_last_d;
    logic        fits;
    logic        beat_take;
    logic        accept;

    sext_fit u_fit (
        .word (in_word),
        .op   (in_op),
        .fits (fits)
    );

    assign beat_take = out_valid_q & out_ready;
    assign in_ready  = (state_q == IDLE) | (beat_take & out_last_q);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_short_d = out_short_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: ;
            SEND_LO: begin
                if (beat_take) begin
                    if (out_short_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_short_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        state_d    = SEND_HI;
                        out_last_d = 1'b1;
                    end
                end
            end
            SEND_HI: begin
                if (beat_take) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_short_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_short_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
        // A new word accepted on a final beat overrides the return to IDLE.
        if (accept) begin
            state_d     = SEND_LO;
            word_d      = in_word;
            out_valid_d = 1'b1;
            out_short_d = fits;
            out_last_d  = fits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= 16'h0000;
            out_valid_q <= 1'b0;
            out_short_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_short_q <= out_short_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_short = out_short_q;
    assign out_last  = out_last_q;
    // Byte select comes straight from flops, so it is stable whenever the beat is held.
    assign out_byte  = !out_valid_q          ? 8'h00 :
                       (state_q == SEND_HI) ? word_q[15:8] : word_q[7:0];

`ifdef SEXT_PACK_STATS_EN
    logic [15:0] short_cnt_q, short_cnt_d;

    always_comb begin
        short_cnt_d = short_cnt_q;
        if (beat_take && out_short_q) begin
            short_cnt_d = short_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_cnt_q <= 16'h0000;
        end else begin
            short_cnt_q <= short_cnt_d;
        end
    end

    assign short_cnt = short_cnt_q;
`endif

endmodule

// File: tb/tb_sext_pack.sv
// Self-checking bench for sext_pack: queue-based beat model plus directed literal checks.
module tb_sext_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_word = 16'h0000;
    logic        in_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_short;
    logic        out_last;
`ifdef SEXT_PACK_STATS_EN
    logic [15:0] short_cnt;
    logic [15:0] cnt_m = 16'h0000;
`endif

    sext_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_short (out_short),
        .out_last  (out_last)
`ifdef SEXT_PACK_STATS_EN
        ,
        .short_cnt (short_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(negedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Beats are {byte, short, last}; a word's beats are queued when it is accepted.
    logic [9:0] exp_q[$];
    logic       m_valid;
    logic       m_ready;

    function automatic logic fits_model(input logic [15:0] w, input logic op);
        int v;
        v = $signed(w);
        if (op) return (v >= -128 && v <= 127);
        return (v >= -16 && v <= 15);
    endfunction

    always_comb begin
        m_valid = (exp_q.size() > 0);
        m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
`ifdef SEXT_PACK_STATS_EN
            cnt_m = 16'h0000;
`endif
        end else begin
            logic acc;
            acc = in_valid && m_ready;
            if (m_valid && out_ready) begin
`ifdef SEXT_PACK_STATS_EN
                if (exp_q[0][1]) cnt_m = cnt_m + 16'd1;
`endif
                void'(exp_q.pop_front());
            end
            if (acc) begin
                if (fits_model(in_word, in_op)) begin
                    exp_q.push_back({in_word[7:0], 1'b1, 1'b1});
                end else begin
                    exp_q.push_back({in_word[7:0], 1'b0, 1'b0});
                    exp_q.push_back({in_word[15:8], 1'b0, 1'b1});
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("out_valid", out_valid, m_valid);
            check("in_ready", in_ready, m_ready);
            if (exp_q.size() > 0) begin
                check("beat", {out_byte, out_short, out_last}, exp_q[0]);
            end
`ifdef SEXT_PACK_STATS_EN
            check("short_cnt", short_cnt, cnt_m);
`endif
        end
    end

    // Log of beats actually taken, for the directed literal checks.
    logic [9:0] got_q[$];
    int         got_cyc[$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_byte, out_short, out_last});
            got_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] w, input logic op);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_word  = w;
        in_op    = op;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(posedge clk);
            ok = in_ready;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 16'($urandom_range(0, 65535));
        in_op    = 1'($urandom_range(0, 1));
        check("send_accept", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_word  = 16'($urandom_range(0, 65535));
        in_op    = 1'($urandom_range(0, 1));
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    // Boundary table: word, op, expected short flag.
    logic [15:0] bw [8] = '{16'h000F, 16'hFFF0, 16'hFFEF, 16'h0008,
                            16'h007F, 16'h0080, 16'hFF7F, 16'h0000};
    logic        bo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bs [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // ---------------- stimulus ----------------
    initial begin
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_short", out_short, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);
        idle(2);

        // Short 8-bit word.
        clear_log();
        send(16'hFF80, 1'b1);
        idle(3);
        check("t1_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("t1_beat0", got_q[0], {8'h80, 1'b1, 1'b1});

        // Long 5-bit word.
        clear_log();
        send(16'h0010, 1'b0);
        idle(4);
        check("t2_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("t2_beat0", got_q[0], {8'h10, 1'b0, 1'b0});
            check("t2_beat1", got_q[1], {8'h00, 1'b0, 1'b1});
        end

        // Backpressure hold.
        clear_log();
        out_ready = 1'b0;
        send(16'h1234, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_valid", out_valid, 1'b1);
            check("t3_hold_byte", out_byte, 8'h34);
            @(negedge clk);
        end
        out_ready = 1'b1;
        idle(4);
        check("t3_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("t3_beat0", got_q[0], {8'h34, 1'b0, 1'b0});
            check("t3_beat1", got_q[1], {8'h12, 1'b0, 1'b1});
            check("t3_gap", got_cyc[1] - got_cyc[0], 1);
        end

        // Back-to-back words, no idle cycle.
        clear_log();
        send(16'h0005, 1'b1);
        send(16'hFFFF, 1'b1);
        send(16'h0100, 1'b1);
        idle(4);
        check("t4_count", got_q.size(), 4);
        if (got_q.size() >= 4) begin
            check("t4_beat0", got_q[0], {8'h05, 1'b1, 1'b1});
            check("t4_beat1", got_q[1], {8'hFF, 1'b1, 1'b1});
            check("t4_beat2", got_q[2], {8'h00, 1'b0, 1'b0});
            check("t4_beat3", got_q[3], {8'h01, 1'b0, 1'b1});
            for (int i = 0; i < 3; i++) check("t4_consecutive", got_cyc[i+1] - got_cyc[i], 1);
        end

        // Field-width boundaries.
        for (int i = 0; i < 8; i++) begin
            clear_log();
            send(bw[i], bo[i]);
            idle(4);
            check("t5_count", got_q.size(), bs[i] ? 1 : 2);
            if (got_q.size() >= 1) check("t5_first", got_q[0], {bw[i][7:0], bs[i], bs[i]});
        end

        // Reset during the high beat.
        clear_log();
        send(16'hABCD, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 1'b0);
        check("t6_rst_byte", out_byte, 8'h00);
        check("t6_rst_last", out_last, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_in_ready", in_ready, 1'b1);
        idle(4);
        check("t6_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("t6_beat0", got_q[0], {8'hCD, 1'b0, 1'b0});

`ifdef SEXT_PACK_STATS_EN
        // Counter wrap; the reset above cleared it.
        for (int i = 0; i < 65535; i++) send(16'hFFFF, 1'b1);
        idle(2);
        check("t7_cnt_max", short_cnt, 16'hFFFF);
        send(16'hFFFF, 1'b1);
        idle(2);
        check("t7_cnt_wrap", short_cnt, 16'h0000);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
